// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver:
//   - uart_state_e     : frame-level FSM state encoding (IDLE/START/DATA/PARITY/STOP)
//   - DATA_WIDTH_DEF   : default payload width in bits
//   - PRESCALE_W       : width of the PRESCALE (cycles-per-bit) configuration
//   - PRESCALE_MIN_DEF : default lower bound applied to PRESCALE
//   - PAR_EVEN/PAR_ODD : encodings of the PAR_TYP configuration input
//   - clamp_prescale() : applies the lower bound to a requested bit period
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int PRESCALE_W       = 5;
  localparam int PRESCALE_MIN_DEF = 4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Bit periods below the minimum are raised to the minimum; anything at or
  // above it (up to 31) is used unchanged.
  function automatic logic [PRESCALE_W-1:0] clamp_prescale(
    input logic [PRESCALE_W-1:0] req,
    input logic [PRESCALE_W-1:0] min_p
  );
    return (req < min_p) ? min_p : req;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Loadable bit-period counter. A load captures the period and restarts the
// count at 0; while enabled the count runs 0..period-1 and wraps. bit_done is
// high during the last cycle of each period, so a state machine that advances
// on bit_done advances on the edge where the count wraps.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active-high (count=0)
//   load      in   capture period and restart the count (takes priority)
//   period    in   bit period in cycles, already clamped by the caller
//   en        in   count enable
//   bit_done  out  last cycle of the current bit period (combinational)
// -----------------------------------------------------------------------------
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [PRESCALE_W-1:0] period,
  input  logic                  en,
  output logic                  bit_done
);

  logic [PRESCALE_W-1:0] count_reg;
  logic [PRESCALE_W-1:0] period_reg;
  logic                  at_end;

  assign at_end   = (count_reg == (period_reg - PRESCALE_W'(1)));
  assign bit_done = en && !load && at_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg  <= '0;
      period_reg <= PRESCALE_W'(PRESCALE_MIN_DEF);
    end else if (load) begin
      count_reg  <= '0;
      period_reg <= period;
    end else if (en) begin
      if (at_end) begin
        count_reg <= '0;
      end else begin
        count_reg <= count_reg + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Serial transmitter. One byte is accepted per DATA_VALID handshake while idle
// and sent as start(0) / data LSB first / optional parity / stop(1), each bit
// lasting the latched PRESCALE cycles. The configuration is latched on the
// accepting edge, so mid-frame changes on any input have no effect.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous reset, active-high; abandons any frame
//   PRESCALE   in   cycles per serial bit (values below PRESCALE_MIN are raised)
//   PAR_EN     in   1 = insert a parity bit after the data bits
//   PAR_TYP    in   0 = even parity, 1 = odd parity
//   P_DATA     in   byte to send, sampled on the accepting edge
//   DATA_VALID in   send request, honoured only while BUSY=0
//   TX_OUT     out  serial line, idles high (registered)
//   BUSY       out  high from the accepting edge until the stop bit ends (registered)
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int PRESCALE_MIN = PRESCALE_MIN_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  uart_state_e           state_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [IDX_W-1:0]      bit_idx_reg;
  logic                  par_en_reg;
  logic                  par_bit_reg;
  logic                  tx_reg;
  logic                  busy_reg;

  logic                  accept;
  logic                  bit_done;
  logic [PRESCALE_W-1:0] period_clamped;
  logic                  par_bit_next;

  // Acceptance is only possible in IDLE; BUSY is low exactly when IDLE.
  assign accept         = (state_reg == ST_IDLE) && DATA_VALID;
  assign period_clamped = clamp_prescale(PRESCALE, PRESCALE_W'(PRESCALE_MIN));
  assign par_bit_next   = (PAR_TYP == PAR_ODD) ? ~(^P_DATA) : (^P_DATA);

  // The timer is restarted on the accepting edge, so its first period lines
  // up with the start bit that becomes visible on that same edge.
  uart_bit_timer u_bit_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (accept),
    .period   (period_clamped),
    .en       (state_reg != ST_IDLE),
    .bit_done (bit_done)
  );

  // TX_OUT is registered: every transition loads the level of the bit that
  // the new state will drive, so the line changes on the same edge as the
  // state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          tx_reg   <= 1'b1;
          busy_reg <= 1'b0;
          if (accept) begin
            shift_reg   <= P_DATA;
            bit_idx_reg <= '0;
            par_en_reg  <= PAR_EN;
            par_bit_reg <= par_bit_next;
            tx_reg      <= 1'b0;
            busy_reg    <= 1'b1;
            state_reg   <= ST_START;
          end
        end

        ST_START: begin
          if (bit_done) begin
            tx_reg    <= shift_reg[0];
            state_reg <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (bit_done) begin
            shift_reg <= shift_reg >> 1;
            if (bit_idx_reg == LAST_IDX) begin
              bit_idx_reg <= '0;
              if (par_en_reg) begin
                tx_reg    <= par_bit_reg;
                state_reg <= ST_PARITY;
              end else begin
                tx_reg    <= 1'b1;
                state_reg <= ST_STOP;
              end
            end else begin
              // Next data bit is the one about to shift into position 0.
              tx_reg      <= shift_reg[1];
              bit_idx_reg <= bit_idx_reg + IDX_W'(1);
            end
          end
        end

        ST_PARITY: begin
          if (bit_done) begin
            tx_reg    <= 1'b1;
            state_reg <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (bit_done) begin
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign TX_OUT = tx_reg;
  assign BUSY   = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Directed bench for uart_tx: a table of frames with hand-computed serial
// patterns and BUSY lengths, plus hand-written sequences for mid-frame
// requests, asynchronous reset and held DATA_VALID.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [4:0] PRESCALE = 5'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic       TX_OUT;
  logic       BUSY;

  int checks = 0;
  int errors = 0;

  uart_tx dut (
    .CLK        (CLK),
    .RST        (RST),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  // frame[j] is the j-th bit on the line (bit 0 = start bit).
  typedef struct {
    logic [4:0]  prescale;
    logic        par_en;
    logic        par_typ;
    logic [7:0]  data;
    int          eff_p;
    int          nbits;
    logic [10:0] frame;
    int          busy_len;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Sends table entry idx with a one-cycle DATA_VALID and checks every cycle
  // of the frame. With inject set, a competing request with different data
  // and configuration is raised in the middle of the frame.
  task automatic run_frame(input int idx, input bit inject);
    int k;
    int j;
    int mism;
    int idle_busy;
    int p;
    p = vecs[idx].eff_p;
    @(negedge CLK);
    PRESCALE   = vecs[idx].prescale;
    PAR_EN     = vecs[idx].par_en;
    PAR_TYP    = vecs[idx].par_typ;
    P_DATA     = vecs[idx].data;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    k = 0;
    mism = 0;
    while (BUSY === 1'b1 && k < 1200) begin
      if (k < vecs[idx].nbits * p) begin
        j = k / p;
        if (TX_OUT !== vecs[idx].frame[j]) mism++;
        if (k == j * p + p / 2)
          check($sformatf("v%0d bit%0d", idx, j), {31'd0, TX_OUT}, {31'd0, vecs[idx].frame[j]});
      end
      if (inject) begin
        if (k == 20) begin
          DATA_VALID = 1'b1;
          P_DATA     = 8'h00;
          PRESCALE   = 5'd4;
          PAR_EN     = 1'b0;
        end
        if (k == 40) DATA_VALID = 1'b0;
      end
      @(negedge CLK);
      k++;
    end
    DATA_VALID = 1'b0;
    check($sformatf("v%0d busy_len", idx), k, vecs[idx].busy_len);
    check($sformatf("v%0d tx_cycle_mismatches", idx), mism, 0);
    check($sformatf("v%0d tx_idle_after", idx), {31'd0, TX_OUT}, 32'd1);
    idle_busy = 0;
    for (int i = 0; i < 16; i++) begin
      if (BUSY !== 1'b0 || TX_OUT !== 1'b1) idle_busy++;
      @(negedge CLK);
    end
    check($sformatf("v%0d idle_cycles_not_idle", idx), idle_busy, 0);
    $display("frame v%0d data=%02h prescale=%0d par_en=%0d par_typ=%0d inject=%0d busy=%0d",
             idx, vecs[idx].data, vecs[idx].prescale, vecs[idx].par_en, vecs[idx].par_typ,
             inject, k);
  endtask

  initial begin
    int k;
    int g;
    logic gap_tx;

    // 0xA5, even parity 0: 0 1010 0101(LSB first: 1,0,1,0,0,1,0,1) 0 1
    vecs[0] = '{5'd8,  1'b1, 1'b0, 8'hA5, 8,  11, 11'b10101001010, 88};
    // 0x3C, odd parity 1: 0 | 0,0,1,1,1,1,0,0 | 1 | 1
    vecs[1] = '{5'd16, 1'b1, 1'b1, 8'h3C, 16, 11, 11'b11001111000, 176};
    // 0xFF, no parity: 0, eight 1s, stop 1
    vecs[2] = '{5'd16, 1'b0, 1'b0, 8'hFF, 16, 10, 11'b01111111110, 160};
    // PRESCALE=2 clamped to 4; 0x81 no parity: 0 | 1,0,0,0,0,0,0,1 | 1
    vecs[3] = '{5'd2,  1'b0, 1'b0, 8'h81, 4,  10, 11'b01100000010, 40};
    // PRESCALE=31; 0x01 even parity 1: 0 | 1,0..0 | 1 | 1
    vecs[4] = '{5'd31, 1'b1, 1'b0, 8'h01, 31, 11, 11'b11000000010, 341};
    // PRESCALE=0 clamped to 4; 0x00 odd parity 1
    vecs[5] = '{5'd0,  1'b1, 1'b1, 8'h00, 4,  11, 11'b11000000000, 44};
    // PRESCALE=4; 0x7E even parity 0: 0 | 0,1,1,1,1,1,1,0 | 0 | 1
    vecs[6] = '{5'd4,  1'b1, 1'b0, 8'h7E, 4,  11, 11'b10011111100, 44};

    // Reset state, during and right after reset.
    repeat (3) @(negedge CLK);
    check("reset tx", {31'd0, TX_OUT}, 32'd1);
    check("reset busy", {31'd0, BUSY}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("post-reset tx", {31'd0, TX_OUT}, 32'd1);
    check("post-reset busy", {31'd0, BUSY}, 32'd0);

    // Table-driven frames.
    for (int i = 0; i < 7; i++) run_frame(i, 1'b0);

    // Competing request plus config change mid-frame must not disturb it.
    run_frame(0, 1'b1);

    // Asynchronous reset during a low data bit (cycle 20 of a PRESCALE=8 frame).
    @(negedge CLK);
    PRESCALE = 5'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0; P_DATA = 8'hA5;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    repeat (20) @(negedge CLK);
    check("pre-reset mid-frame busy", {31'd0, BUSY}, 32'd1);
    check("pre-reset mid-frame tx", {31'd0, TX_OUT}, 32'd0);
    RST = 1'b1;
    #1;
    check("async reset tx", {31'd0, TX_OUT}, 32'd1);
    check("async reset busy", {31'd0, BUSY}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("after mid-frame reset tx", {31'd0, TX_OUT}, 32'd1);
    check("after mid-frame reset busy", {31'd0, BUSY}, 32'd0);
    $display("reset mid-frame at cycle 20 applied");
    run_frame(0, 1'b0);

    // Held DATA_VALID: back-to-back frames separated by one idle-high cycle.
    @(negedge CLK);
    PRESCALE = 5'd0; PAR_EN = 1'b1; PAR_TYP = 1'b1; P_DATA = 8'h00;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    k = 0;
    while (BUSY === 1'b1 && k < 500) begin
      @(negedge CLK);
      k++;
    end
    check("held first busy_len", k, 44);
    g = 0;
    gap_tx = TX_OUT;
    while (BUSY === 1'b0 && g < 50) begin
      @(negedge CLK);
      g++;
    end
    check("held idle gap", g, 1);
    check("held gap tx", {31'd0, gap_tx}, 32'd1);
    check("held second start bit", {31'd0, TX_OUT}, 32'd0);
    DATA_VALID = 1'b0;
    k = 0;
    while (BUSY === 1'b1 && k < 500) begin
      @(negedge CLK);
      k++;
    end
    check("held second busy_len", k, 44);
    $display("held DATA_VALID: gap=%0d second busy=%0d", g, k);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
